encoding_scheduler: RTL and testbench



---
 rtl/encoding_scheduler.sv | 129 ++++++++++++
 tb/tb_encoding_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoding_scheduler.sv
// rtl/encoding_scheduler.sv - round-robin scheduler sharing one encoding datapath among sample requesters
// Launches each encoding, supervises it with a done/timeout watchdog and returns the tagged result.
module encoding_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int HV_DIM         = 80,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_sel,
  output logic                       enc_en,
  output logic                       enc_start,
  input  logic                       enc_done,
  input  logic [HV_DIM-1:0]          enc_hv,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [HV_DIM-1:0]          out_hv,
  output logic [$clog2(NUM_REQ)-1:0] out_tag,
  output logic                       busy,
  output logic                       timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_CAPTURE, S_HOLD} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] next_ptr;
  logic          pick_found;
  logic [IW:0]   scan_idx;
  logic [WW-1:0] wd_cnt;

  // First pending request at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    scan_idx   = '0;
    req_ready  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (IW+1)'(NUM_REQ);
      end
      if (!pick_found && req_valid[scan_idx[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[IW-1:0];
      end
    end
    if (state == S_IDLE && !rst && pick_found) begin
      req_ready[pick_idx] = 1'b1;
    end
  end

  assign next_ptr = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_sel   <= '0;
      wd_cnt      <= '0;
      out_hv      <= '0;
      out_tag     <= '0;
      enc_en      <= 1'b0;
      enc_start   <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      enc_start   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req_ready) begin
            grant_sel <= pick_idx;
            rr_ptr    <= next_ptr;
            enc_start <= 1'b1;
            enc_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
          // Completion wins over the watchdog when both land on the same cycle.
          if (enc_done) begin
            enc_en <= 1'b0;
            state  <= S_CAPTURE;
          end else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
            enc_en      <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_CAPTURE: begin
          out_hv    <= enc_hv;
          out_tag   <= grant_sel;
          out_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          enc_en    <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoding_scheduler.sv
// tb/tb_encoding_scheduler.sv - scoreboard bench for encoding_scheduler
// An encoder stand-in answers each start; a cycle-level expectation model checks every output.
module tb_encoding_scheduler;
  localparam int N   = 2;
  localparam int HVW = 80;
  localparam int TO  = 16;
  localparam int BIG = 1 << 30;

  logic                 clk;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [$clog2(N)-1:0] grant_sel;
  logic                 enc_en;
  logic                 enc_start;
  logic                 enc_done;
  logic [HVW-1:0]       enc_hv;
  logic                 out_valid;
  logic                 out_ready;
  logic [HVW-1:0]       out_hv;
  logic [$clog2(N)-1:0] out_tag;
  logic                 busy;
  logic                 timeout_err;

  encoding_scheduler #(.NUM_REQ(N), .HV_DIM(HVW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .grant_sel(grant_sel), .enc_en(enc_en), .enc_start(enc_start),
    .enc_done(enc_done), .enc_hv(enc_hv), .out_valid(out_valid),
    .out_ready(out_ready), .out_hv(out_hv), .out_tag(out_tag),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct { int tag; int lat; } job_t;
  typedef struct { logic [HVW-1:0] hv; int tag; } res_t;

  job_t job_q[$];
  res_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_count = 0;
  int next_lat = 10;
  bit force_hv = 0;
  bit rand_ready = 0;

  int m_rr = 0, m_grant = 0, m_idle_at = 0;
  int m_start_at = BIG, m_en_lo = BIG, m_en_hi = -1, m_ov_from = BIG, m_to_at = BIG;
  logic [HVW-1:0] m_last_hv = '0;
  int m_last_tag = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  // Expectation model: what each output must be in every cycle, derived from request/latency choices.
  initial begin
    logic [N-1:0] exp_rdy;
    int g, s, lat;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_rr = 0; m_grant = 0; m_idle_at = cyc + 1;
        m_start_at = BIG; m_en_lo = BIG; m_en_hi = -1; m_ov_from = BIG; m_to_at = BIG;
        m_last_hv = '0; m_last_tag = 0;
        exp_q.delete();
        job_q.delete();
      end else begin
        exp_rdy = '0;
        g = 0;
        if (cyc >= m_idle_at) begin
          for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (req_valid[i] && exp_rdy == '0) begin
              exp_rdy[i] = 1'b1;
              g = i;
            end
          end
        end
        chk("req_ready", req_ready, exp_rdy);
        chk("busy", busy, cyc < m_idle_at);
        chk("enc_start", enc_start, cyc == m_start_at);
        chk("enc_en", enc_en, cyc >= m_en_lo && cyc <= m_en_hi);
        chk("timeout_err", timeout_err, cyc == m_to_at);
        chk("out_valid", out_valid, cyc >= m_ov_from);
        chk("grant_sel", grant_sel, m_grant);
        if (cyc >= m_ov_from) begin
          if (exp_q.size() == 0) begin
            chk("exp_q_depth", exp_q.size(), 1);
          end else begin
            chk("out_hv", out_hv, exp_q[0].hv);
            chk("out_tag", out_tag, exp_q[0].tag);
            if (out_ready) begin
              m_last_hv = exp_q[0].hv;
              m_last_tag = exp_q[0].tag;
              void'(exp_q.pop_front());
              m_ov_from = BIG;
              m_idle_at = cyc + 1;
            end
          end
        end else begin
          chk("out_hv_hold", out_hv, m_last_hv);
          chk("out_tag_hold", out_tag, m_last_tag);
        end
        if (exp_rdy != '0) begin
          lat = next_lat;
          m_grant = g;
          m_rr = (g + 1) % N;
          job_q.push_back('{tag: g, lat: lat});
          s = cyc + 1;
          m_start_at = s;
          m_en_lo = s;
          m_en_hi = s + ((lat <= TO) ? lat : TO);
          if (lat <= TO) begin
            m_ov_from = s + lat + 2; m_to_at = BIG; m_idle_at = BIG;
          end else begin
            m_ov_from = BIG; m_to_at = s + TO + 1; m_idle_at = s + TO + 1;
          end
          acc_count++;
        end
      end
    end
  end

  // Encoder stand-in: done 'lat' cycles after start; lat > TO lands done after the abort.
  initial begin
    bit st, r, active;
    int cnt, tag, lat, garble;
    logic [95:0] r96;
    job_t j;
    active = 0; cnt = 0; tag = 0; lat = 0; garble = 0;
    enc_done = 0;
    enc_hv = '0;
    forever begin
      @(negedge clk);
      st = enc_start;
      r = rst;
      @(posedge clk);
      #1;
      enc_done = 0;
      if (r) begin
        active = 0;
        garble = 0;
        continue;
      end
      if (garble > 0) begin
        garble--;
        if (garble == 0) begin
          r96 = {$urandom, $urandom, $urandom};
          enc_hv = r96[HVW-1:0];
        end
      end
      if (st && job_q.size() > 0) begin
        j = job_q.pop_front();
        active = 1; cnt = j.lat; tag = j.tag; lat = j.lat;
      end
      if (active) begin
        cnt--;
        if (cnt == 0) begin
          active = 0;
          r96 = {$urandom, $urandom, $urandom};
          enc_hv = force_hv ? {10{8'hA5}} : r96[HVW-1:0];
          enc_done = 1;
          if (lat <= TO) begin
            exp_q.push_back('{hv: enc_hv, tag: tag});
            garble = 2;
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_accept(input int a0);
    int t = 0;
    while (acc_count == a0 && t < 400) begin
      step(1);
      t++;
    end
    chk("accept_wait", t < 400, 1);
  endtask

  task automatic issue(input logic [N-1:0] pat, input int lat);
    int a0 = acc_count;
    next_lat = lat;
    req_valid = pat;
    wait_accept(a0);
    req_valid = '0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (cyc < m_idle_at && t < 400) begin
      step(1);
      t++;
    end
    chk("idle_wait", t < 400, 1);
  endtask

  task automatic wait_hold();
    int t = 0;
    while (cyc < m_ov_from && t < 400) begin
      step(1);
      t++;
    end
    chk("hold_wait", t < 400, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1;
    req_valid = '0;
    out_ready = 0;
    step(3);
    rst = 0;
    step(2);

    // single request, fixed pattern result
    out_ready = 1;
    force_hv = 1;
    issue(2'b01, 10);
    wait_idle();
    force_hv = 0;

    // round-robin with both requesters held
    for (int e = 0; e < 4; e++) begin
      int a0 = acc_count;
      next_lat = $urandom_range(1, TO);
      req_valid = 2'b11;
      wait_accept(a0);
    end
    req_valid = '0;
    wait_idle();

    // backpressure in HOLD with requests pending
    out_ready = 0;
    issue(2'b11, 5);
    wait_hold();
    req_valid = 2'b11;
    next_lat = 4;
    step(20);
    begin
      int a0 = acc_count;
      out_ready = 1;
      wait_accept(a0);
    end
    req_valid = '0;
    wait_idle();

    // watchdog abort, then next request follows the advanced pointer
    issue(2'b01, TO + 1);
    wait_idle();
    issue(2'b11, 3);
    wait_idle();

    // done on the final watchdog cycle
    issue(2'b10, TO);
    wait_idle();

    // reset mid-WAIT
    issue(2'b10, TO);
    step(6);
    rst = 1;
    step(1);
    rst = 0;
    step(2);
    issue(2'b11, 4);
    wait_idle();

    // reset mid-HOLD
    out_ready = 0;
    issue(2'b10, 3);
    wait_hold();
    step(3);
    rst = 1;
    step(1);
    rst = 0;
    out_ready = 1;
    step(2);
    issue(2'b11, 2);
    wait_idle();

    // randomized traffic with random consumer readiness
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      issue(N'($urandom_range(1, 3)), $urandom_range(1, TO + 1));
      step($urandom_range(0, 3));
    end
    rand_ready = 0;
    out_ready = 1;
    wait_idle();
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
